// File: rtl/pll_mult_reconfig_ctrl.sv
// PLL feedback-multiplier reconfiguration sequencer.
// Takes a multiplier request and holds the PLL in reset. Writes the multiplier
// register over MDRP and reads it back. Then releases reset and waits for lock,
// retrying the whole sequence on lock timeout. After reset it runs a write-less
// boot path (reset pulse, release, wait for lock) before accepting requests.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | ready for a request; pll_rst holds whatever the last run left
// RST_ASSERT | pll_rst high, counting RST_CYCLES
// ADDR       | MDRP load-address strobe (MULT_ADDR)
// WRITE      | MDRP write-data strobe (latched multiplier)
// RD_ADDR    | MDRP load-address strobe for readback
// READ       | MDRP read strobe
// RD_WAIT    | wait RD_LATENCY cycles, compare mdrdo with multiplier
// RELEASE    | pll_rst low, lock timer loaded
// LOCK_WAIT  | wait for synced lock or timer terminal count
module pll_mult_reconfig_ctrl #(
  parameter logic [7:0] MULT_ADDR    = 8'h04,
  parameter int         MULT_MIN     = 2,
  parameter int         MULT_MAX     = 64,
  parameter int         RST_CYCLES   = 16,
  parameter int         RD_LATENCY   = 2,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         MAX_RETRY    = 3
) (
  input  logic       mdclk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_mult,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] cur_mult,
  input  logic       pll_lock,
  output logic       lock,
  output logic       pll_rst,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_RST_ASSERT = 4'd1;
  localparam logic [3:0] S_ADDR       = 4'd2;
  localparam logic [3:0] S_WRITE      = 4'd3;
  localparam logic [3:0] S_RD_ADDR    = 4'd4;
  localparam logic [3:0] S_READ       = 4'd5;
  localparam logic [3:0] S_RD_WAIT    = 4'd6;
  localparam logic [3:0] S_RELEASE    = 4'd7;
  localparam logic [3:0] S_LOCK_WAIT  = 4'd8;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ADDR  = 2'b11;

  localparam logic [1:0] EC_RANGE    = 2'b01;
  localparam logic [1:0] EC_READBACK = 2'b10;
  localparam logic [1:0] EC_TIMEOUT  = 2'b11;

  // Counters hold limit-1 at most, so $clog2 of the limit is always wide enough.
  localparam int RST_W = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
  localparam int RD_W  = (RD_LATENCY   > 1) ? $clog2(RD_LATENCY)   : 1;
  localparam int LT_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRY    > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RST_CYCLES - 1);
  localparam logic [RD_W-1:0]  RD_LOAD   = RD_W'(RD_LATENCY - 1);
  localparam logic [LT_W-1:0]  LT_LOAD   = LT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(MAX_RETRY);
  localparam logic [7:0]       MIN8      = 8'(MULT_MIN);
  localparam logic [7:0]       MAX8      = 8'(MULT_MAX);

  logic [3:0]       state_q,    state_d;
  logic             boot_q,     boot_d;
  logic [7:0]       mult_q,     mult_d;
  logic [RTY_W-1:0] retry_q,    retry_d;
  logic [RST_W-1:0] rst_cnt_q,  rst_cnt_d;
  logic [RD_W-1:0]  rd_cnt_q,   rd_cnt_d;
  logic [LT_W-1:0]  lock_tmr_q, lock_tmr_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       cur_mult_q, cur_mult_d;
  logic             pll_rst_q,  pll_rst_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_sync_q, lock_sync_d;
  logic             lock_q,     lock_d;

  logic             req_in_range;

  assign req_in_range = (req_mult >= MIN8) && (req_mult <= MAX8);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    mult_d      = mult_q;
    retry_d     = retry_q;
    rst_cnt_d   = rst_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    lock_tmr_d  = lock_tmr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    cur_mult_d  = cur_mult_q;
    pll_rst_d   = pll_rst_q;
    lock_meta_d = pll_lock;
    lock_sync_d = lock_meta_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mult_d  = req_mult;
          retry_d = '0;
          if (req_in_range) begin
            busy_d    = 1'b1;
            pll_rst_d = 1'b1;
            rst_cnt_d = RST_LOAD;
            state_d   = S_RST_ASSERT;
          end else begin
            err_d      = 1'b1;
            err_code_d = EC_RANGE;
          end
        end
      end

      S_RST_ASSERT: begin
        pll_rst_d = 1'b1;
        if (rst_cnt_q == '0) begin
          if (boot_q) begin
            pll_rst_d  = 1'b0;
            lock_tmr_d = LT_LOAD;
            state_d    = S_RELEASE;
          end else begin
            state_d = S_ADDR;
          end
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end

      S_ADDR:    state_d = S_WRITE;
      S_WRITE:   state_d = S_RD_ADDR;
      S_RD_ADDR: state_d = S_READ;

      S_READ: begin
        rd_cnt_d = RD_LOAD;
        state_d  = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (rd_cnt_q == '0) begin
          if (mdrdo == mult_q) begin
            pll_rst_d  = 1'b0;
            lock_tmr_d = LT_LOAD;
            state_d    = S_RELEASE;
          end else begin
            // PLL stays in reset: its multiplier register is in an unknown state.
            err_d      = 1'b1;
            err_code_d = EC_READBACK;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q - RD_W'(1);
        end
      end

      S_RELEASE: state_d = S_LOCK_WAIT;

      S_LOCK_WAIT: begin
        if (lock_sync_q) begin
          state_d = S_IDLE;
          boot_d  = 1'b0;
          if (!boot_q) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            cur_mult_d = mult_q;
          end
        end else if (lock_tmr_q == '0) begin
          pll_rst_d = 1'b1;
          if (retry_q < RETRY_LIM) begin
            retry_d   = retry_q + RTY_W'(1);
            rst_cnt_d = RST_LOAD;
            state_d   = S_RST_ASSERT;
          end else begin
            state_d = S_IDLE;
            boot_d  = 1'b0;
            if (!boot_q) begin
              err_d      = 1'b1;
              err_code_d = EC_TIMEOUT;
              busy_d     = 1'b0;
            end
          end
        end else begin
          lock_tmr_d = lock_tmr_q - LT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Using busy_d lets lock rise in the same cycle as the done pulse.
    lock_d = lock_sync_q & ~busy_d;
  end

  // State and output registers with synchronous reset into the boot path.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      state_q     <= S_RST_ASSERT;
      boot_q      <= 1'b1;
      mult_q      <= '0;
      retry_q     <= '0;
      rst_cnt_q   <= RST_LOAD;
      rd_cnt_q    <= '0;
      lock_tmr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      cur_mult_q  <= '0;
      pll_rst_q   <= 1'b1;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      mult_q      <= mult_d;
      retry_q     <= retry_d;
      rst_cnt_q   <= rst_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      lock_tmr_q  <= lock_tmr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cur_mult_q  <= cur_mult_d;
      pll_rst_q   <= pll_rst_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      lock_q      <= lock_d;
    end
  end

  // MDRP strobes are decoded straight from the state so each lasts one cycle.
  always_comb begin
    mdopc = OP_NOP;
    mdwdi = 8'h00;
    case (state_q)
      S_ADDR: begin
        mdopc = OP_ADDR;
        mdwdi = MULT_ADDR;
      end
      S_WRITE: begin
        mdopc = OP_WRITE;
        mdwdi = mult_q;
      end
      S_RD_ADDR: begin
        mdopc = OP_ADDR;
        mdwdi = MULT_ADDR;
      end
      S_READ: begin
        mdopc = OP_READ;
      end
      default: begin
        mdopc = OP_NOP;
        mdwdi = 8'h00;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cur_mult  = cur_mult_q;
  assign lock      = lock_q;
  assign pll_rst   = pll_rst_q;
  assign mdainc    = 1'b0;

endmodule

// File: tb/tb_pll_mult_reconfig_ctrl.sv
// Directed bench for pll_mult_reconfig_ctrl: boot, good reprogram, range
// rejects, readback mismatch, lock-timeout retries and reset mid-sequence.
// LOCK_TIMEOUT is 120 so the 100-cycle boot lock fits and retries stay short.
module tb_pll_mult_reconfig_ctrl;

  localparam int LT = 120;

  logic       mdclk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_mult;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] cur_mult;
  logic       pll_lock;
  logic       lock;
  logic       pll_rst;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  logic [7:0] echo_q;
  logic       rd_zero;
  logic [9:0] strobe_q[$];
  int         done_cnt;
  int         err_cnt;
  int         wr30_cnt;
  int         n_checks;
  int         n_errors;

  pll_mult_reconfig_ctrl #(.LOCK_TIMEOUT(LT)) dut (
    .mdclk     (mdclk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_mult  (req_mult),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .cur_mult  (cur_mult),
    .pll_lock  (pll_lock),
    .lock      (lock),
    .pll_rst   (pll_rst),
    .mdopc     (mdopc),
    .mdainc    (mdainc),
    .mdwdi     (mdwdi),
    .mdrdo     (mdrdo)
  );

  always #5 mdclk = ~mdclk;

  // Multiplier register model: echoes the last written value unless forced to zero.
  always @(posedge mdclk) begin
    if (mdopc == 2'b01) echo_q <= mdwdi;
  end
  assign mdrdo = rd_zero ? 8'h00 : echo_q;

  // Strobe and pulse monitor.
  always @(negedge mdclk) begin
    if (mdopc != 2'b00) strobe_q.push_back({mdopc, mdwdi});
    if (mdopc == 2'b01 && mdwdi == 8'd30) wr30_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mdclk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] m);
    req_valid = 1'b1;
    req_mult  = m;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rst_low(input string tag, input int lim);
    int n;
    n = 0;
    while (pll_rst && n < lim) begin
      tick();
      n++;
    end
    check_val(tag, pll_rst, 1'b0);
  endtask

  initial begin
    int n;
    int wr;
    echo_q    = 8'h00;
    rd_zero   = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_mult  = 8'h00;
    pll_lock  = 1'b0;
    done_cnt  = 0;
    err_cnt   = 0;
    wr30_cnt  = 0;
    n_checks  = 0;
    n_errors  = 0;

    // 1: reset values and boot path
    repeat (4) tick();
    check_val("rst_req_ready", req_ready, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_pll_rst", pll_rst, 1'b1);
    check_val("rst_mdopc", mdopc, 2'b00);
    check_val("rst_cur_mult", cur_mult, 8'd0);
    check_val("rst_lock", lock, 1'b0);
    check_val("rst_err_code", err_code, 2'b00);
    reset = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (pll_rst && n < 100);
    check_val("boot_rst_cycles", n, 16);
    repeat (100) tick();
    pll_lock = 1'b1;
    repeat (2) tick();
    check_val("boot_lock_early", lock, 1'b0);
    tick();
    check_val("boot_lock", lock, 1'b1);
    check_val("boot_idle", req_ready, 1'b1);
    check_val("boot_strobes", strobe_q.size(), 0);
    check_val("boot_no_pulse", done_cnt + err_cnt, 0);
    check_val("mdainc", mdainc, 1'b0);

    // 2: reprogram to 18 with echoing readback, lock 50 cycles after release
    strobe_q.delete();
    send_req(8'd18);
    pll_lock = 1'b0;
    check_val("req_busy", busy, 1'b1);
    check_val("req_not_ready", req_ready, 1'b0);
    check_val("req_pll_rst", pll_rst, 1'b1);
    n = 0;
    while (mdopc == 2'b00 && n < 100) begin
      n++;
      tick();
    end
    check_val("req_rst_cycles", n, 16);
    wait_rst_low("req_release_seen", 50);
    repeat (50) tick();
    pll_lock = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check_val("done_latency", n, 3);
    check_val("done_busy", busy, 1'b0);
    check_val("done_lock", lock, 1'b1);
    check_val("done_cur_mult", cur_mult, 8'd18);
    check_val("done_pll_rst", pll_rst, 1'b0);
    check_val("strobe_cnt", strobe_q.size(), 4);
    check_val("strobe0", strobe_q[0], 10'h304);
    check_val("strobe1", strobe_q[1], 10'h112);
    check_val("strobe2", strobe_q[2], 10'h304);
    check_val("strobe3", strobe_q[3] & 10'h300, 10'h200);
    tick();
    check_val("done_pulse_width", done, 1'b0);

    // 3: out-of-range requests just below and above the accepted window
    strobe_q.delete();
    send_req(8'd1);
    check_val("range_lo_err", err, 1'b1);
    check_val("range_lo_code", err_code, 2'b01);
    check_val("range_lo_busy", busy, 1'b0);
    check_val("range_lo_pll_rst", pll_rst, 1'b0);
    tick();
    check_val("range_lo_pulse", err, 1'b0);
    send_req(8'd65);
    check_val("range_hi_err", err, 1'b1);
    check_val("range_hi_code", err_code, 2'b01);
    check_val("range_hi_ready", req_ready, 1'b1);
    tick();
    check_val("range_strobes", strobe_q.size(), 0);
    check_val("range_cur_mult", cur_mult, 8'd18);

    // 4: readback mismatch on the top in-range value 64
    strobe_q.delete();
    rd_zero = 1'b1;
    send_req(8'd64);
    pll_lock = 1'b0;
    n = 0;
    while (!err && n < 100) begin
      tick();
      n++;
    end
    check_val("rb_err", err, 1'b1);
    check_val("rb_code", err_code, 2'b10);
    check_val("rb_pll_rst", pll_rst, 1'b1);
    check_val("rb_cur_mult", cur_mult, 8'd18);
    check_val("rb_busy", busy, 1'b0);
    check_val("rb_write", strobe_q[1], 10'h140);
    rd_zero = 1'b0;

    // 5: lock never arrives on the bottom in-range value 2
    tick();
    strobe_q.delete();
    send_req(8'd2);
    wait_rst_low("to_release_seen", 100);
    n = 0;
    while (!pll_rst && n < 1000) begin
      tick();
      n++;
    end
    check_val("to_rst_low_cycles", n, LT + 1);
    n = 0;
    while (!err && n < 2000) begin
      tick();
      n++;
    end
    check_val("to_err", err, 1'b1);
    check_val("to_code", err_code, 2'b11);
    check_val("to_pll_rst", pll_rst, 1'b1);
    check_val("to_cur_mult", cur_mult, 8'd18);
    wr = 0;
    foreach (strobe_q[i]) if (strobe_q[i] == 10'h102) wr++;
    check_val("to_writes", wr, 4);
    check_val("to_strobes", strobe_q.size(), 16);

    // 6: reset during LOCK_WAIT with a request pulsed while busy
    tick();
    strobe_q.delete();
    send_req(8'd20);
    repeat (3) tick();
    send_req(8'd30);
    wait_rst_low("abort_release_seen", 100);
    check_val("abort_write", strobe_q[1], 10'h114);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_cur_mult", cur_mult, 8'd0);
    check_val("abort_pll_rst", pll_rst, 1'b1);
    check_val("abort_err_code", err_code, 2'b00);
    check_val("abort_ready", req_ready, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    strobe_q.delete();
    wait_rst_low("reboot_release_seen", 100);
    repeat (10) tick();
    pll_lock = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check_val("reboot_idle", req_ready, 1'b1);
    repeat (20) tick();
    check_val("reboot_lock", lock, 1'b1);
    check_val("reboot_strobes", strobe_q.size(), 0);
    check_val("ignored_req", wr30_cnt, 0);
    check_val("total_done", done_cnt, 1);
    check_val("total_err", err_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
